// File: rtl/general_defines.sv
// Shared machine-wide constants and types for the reorder buffer and its neighbours.
package general_defines;

    localparam int ROB_LENGTH     = 16;
    localparam int ROB_IDX_W      = $clog2(ROB_LENGTH);
    localparam int ARCH_REG_IDX_W = 5;
    localparam int PHYS_REG_IDX_W = 6;
    localparam int INT_DATA_W     = 32;

    typedef enum logic {
        RUN        = 1'b0,
        STORE_WAIT = 1'b1
    } rob_commit_state_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// ROB head/tail pointers and occupancy count; full/empty come from the count only.
module rob_ptr_ctrl
    import general_defines::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_i,
    input  logic                 retire_i,
    input  logic                 flush_i,
    output logic [ROB_IDX_W-1:0] head_o,
    output logic [ROB_IDX_W-1:0] tail_o,
    output logic [ROB_IDX_W:0]   count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    logic [ROB_IDX_W-1:0] head_q, head_d;
    logic [ROB_IDX_W-1:0] tail_q, tail_d;
    logic [ROB_IDX_W:0]   count_q, count_d;

    // ROB_LENGTH is a power of two, so natural overflow gives the wrap.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (retire_i) head_d = head_q + ROB_IDX_W'(1);
        if (alloc_i)  tail_d = tail_q + ROB_IDX_W'(1);
        case ({alloc_i, retire_i})
            2'b10:   count_d = count_q + (ROB_IDX_W+1)'(1);
            2'b01:   count_d = count_q - (ROB_IDX_W+1)'(1);
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;
    assign full_o  = (count_q == (ROB_IDX_W+1)'(ROB_LENGTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/rob_commit_ctrl.sv
// ROB head-side controller: allocation, completion tracking, in-order retire and store handshake.
// Optional ROB_FLUSH_EN adds a flush input that empties the ROB on a clock edge.
module rob_commit_ctrl
    import general_defines::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef ROB_FLUSH_EN
    input  logic                      flush,
`endif
    input  logic                      alloc_req,
    output logic                      alloc_gnt,
    output logic                      rob_write,
    output logic [ROB_IDX_W-1:0]      rob_tail,
    output logic [ROB_IDX_W-1:0]      rob_head,
    output logic                      rob_full,
    output logic                      rob_empty,
    input  logic                      wb_valid,
    input  logic [ROB_IDX_W-1:0]      wb_idx,
    input  logic                      head_valid,
    input  logic                      head_is_store,
    input  logic [ARCH_REG_IDX_W-1:0] head_logical_rd,
    input  logic [PHYS_REG_IDX_W-1:0] head_phys_rd,
    input  logic [INT_DATA_W-1:0]     head_result,
    output logic                      commit_valid,
    output logic [ARCH_REG_IDX_W-1:0] commit_logical_rd,
    output logic [PHYS_REG_IDX_W-1:0] commit_phys_rd,
    output logic [INT_DATA_W-1:0]     commit_result,
    output logic                      commit_is_store,
    output logic                      store_commit_valid,
    input  logic                      store_commit_ready
);

    logic flush_w;
`ifdef ROB_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    rob_commit_state_t         state_q, state_d;
    logic [ROB_LENGTH-1:0]     done_q, done_d;
    logic [ROB_IDX_W:0]        rob_count;
    logic                      head_ok;
    logic                      retire;
    logic                      scv_q, scv_d;
    logic                      cvalid_q;
    logic [ARCH_REG_IDX_W-1:0] clrd_q;
    logic [PHYS_REG_IDX_W-1:0] cprd_q;
    logic [INT_DATA_W-1:0]     cres_q;
    logic                      cstore_q;

    // No bypass: a retire in the same cycle does not free a slot for a full ROB.
    assign alloc_gnt = alloc_req & ~rob_full & ~flush_w;
    assign rob_write = alloc_gnt;

    rob_ptr_ctrl u_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .alloc_i  (alloc_gnt),
        .retire_i (retire),
        .flush_i  (flush_w),
        .head_o   (rob_head),
        .tail_o   (rob_tail),
        .count_o  (rob_count),
        .full_o   (rob_full),
        .empty_o  (rob_empty)
    );

    assign head_ok = (rob_count != '0) & head_valid & done_q[rob_head];

    // Allocation clear is applied after writeback so it wins on a shared index.
    always_comb begin
        done_d = done_q;
        if (wb_valid)  done_d[wb_idx]   = 1'b1;
        if (alloc_gnt) done_d[rob_tail] = 1'b0;
        if (flush_w)   done_d           = '0;
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        scv_d   = 1'b0;
        case (state_q)
            RUN: begin
                if (head_ok) begin
                    if (head_is_store) begin
                        state_d = STORE_WAIT;
                        scv_d   = 1'b1;
                    end else begin
                        retire  = 1'b1;
                    end
                end
            end
            STORE_WAIT: begin
                if (store_commit_ready) begin
                    retire  = 1'b1;
                    state_d = RUN;
                end else begin
                    scv_d   = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        if (flush_w) begin
            state_d = RUN;
            retire  = 1'b0;
            scv_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Commit data only loads on a retire and otherwise holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cvalid_q <= 1'b0;
            scv_q    <= 1'b0;
            clrd_q   <= '0;
            cprd_q   <= '0;
            cres_q   <= '0;
            cstore_q <= 1'b0;
        end else begin
            cvalid_q <= retire;
            scv_q    <= scv_d;
            if (retire) begin
                clrd_q   <= head_logical_rd;
                cprd_q   <= head_phys_rd;
                cres_q   <= head_result;
                cstore_q <= (state_q == STORE_WAIT);
            end
        end
    end

    assign commit_valid       = cvalid_q;
    assign commit_logical_rd  = clrd_q;
    assign commit_phys_rd     = cprd_q;
    assign commit_result      = cres_q;
    assign commit_is_store    = cstore_q;
    assign store_commit_valid = scv_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: directed scenarios plus a randomized run against a queue-based ROB model.
module tb_rob_commit_ctrl;
    import general_defines::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst_n;
`ifdef ROB_FLUSH_EN
    logic                      flush;
`endif
    logic                      alloc_req, alloc_gnt, rob_write, rob_full, rob_empty;
    logic [ROB_IDX_W-1:0]      rob_tail, rob_head, wb_idx;
    logic                      wb_valid, head_valid, head_is_store;
    logic [ARCH_REG_IDX_W-1:0] head_logical_rd, commit_logical_rd;
    logic [PHYS_REG_IDX_W-1:0] head_phys_rd, commit_phys_rd;
    logic [INT_DATA_W-1:0]     head_result, commit_result;
    logic                      commit_valid, commit_is_store;
    logic                      store_commit_valid, store_commit_ready;

    int checks = 0;
    int errors = 0;

    // Storage array emulation, written through the DUT's own write port.
    logic                      st_store [ROB_LENGTH];
    logic [ARCH_REG_IDX_W-1:0] st_lrd   [ROB_LENGTH];
    logic [PHYS_REG_IDX_W-1:0] st_prd   [ROB_LENGTH];
    logic [INT_DATA_W-1:0]     st_res   [ROB_LENGTH];
    logic                      al_store;
    logic [ARCH_REG_IDX_W-1:0] al_lrd;
    logic [PHYS_REG_IDX_W-1:0] al_prd;
    logic [INT_DATA_W-1:0]     al_res;
    logic                      hv_en;

    always @(posedge clk) begin
        if (rob_write) begin
            st_store[rob_tail] <= al_store;
            st_lrd[rob_tail]   <= al_lrd;
            st_prd[rob_tail]   <= al_prd;
            st_res[rob_tail]   <= al_res;
        end
    end

    assign head_valid      = hv_en;
    assign head_is_store   = st_store[rob_head];
    assign head_logical_rd = st_lrd[rob_head];
    assign head_phys_rd    = st_prd[rob_head];
    assign head_result     = st_res[rob_head];

    rob_commit_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
`ifdef ROB_FLUSH_EN
        .flush              (flush),
`endif
        .alloc_req          (alloc_req),
        .alloc_gnt          (alloc_gnt),
        .rob_write          (rob_write),
        .rob_tail           (rob_tail),
        .rob_head           (rob_head),
        .rob_full           (rob_full),
        .rob_empty          (rob_empty),
        .wb_valid           (wb_valid),
        .wb_idx             (wb_idx),
        .head_valid         (head_valid),
        .head_is_store      (head_is_store),
        .head_logical_rd    (head_logical_rd),
        .head_phys_rd       (head_phys_rd),
        .head_result        (head_result),
        .commit_valid       (commit_valid),
        .commit_logical_rd  (commit_logical_rd),
        .commit_phys_rd     (commit_phys_rd),
        .commit_result      (commit_result),
        .commit_is_store    (commit_is_store),
        .store_commit_valid (store_commit_valid),
        .store_commit_ready (store_commit_ready)
    );

    typedef struct {
        logic [ROB_IDX_W-1:0]      idx;
        logic                      st;
        logic [ARCH_REG_IDX_W-1:0] lrd;
        logic [PHYS_REG_IDX_W-1:0] prd;
        logic [INT_DATA_W-1:0]     res;
    } ent_t;

    ent_t q[$];
    ent_t last;
    bit   mdone [ROB_LENGTH];
    bit   pend;
    int   mtail;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_req = 0; wb_valid = 0; wb_idx = '0; store_commit_ready = 0;
        al_store = 0; al_lrd = '0; al_prd = '0; al_res = '0; hv_en = 1;
`ifdef ROB_FLUSH_EN
        flush = 0;
`endif
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL rst_commit_valid got %0h exp 0", commit_valid); end
        checks++; if (store_commit_valid !== 1'b0) begin errors++; $display("FAIL rst_scv got %0h exp 0", store_commit_valid); end
        checks++; if (rob_empty !== 1'b1 || rob_full !== 1'b0) begin errors++; $display("FAIL rst_empty_full got %0h%0h exp 10", rob_empty, rob_full); end
        checks++; if (rob_head !== '0 || rob_tail !== '0) begin errors++; $display("FAIL rst_ptrs got %0h/%0h exp 0/0", rob_head, rob_tail); end
        rst_n = 1;
        tick();
        alloc_req = 1;
        #1;
        checks++; if (alloc_gnt !== 1'b1 || rob_write !== 1'b1) begin errors++; $display("FAIL rst_first_gnt got %0h/%0h exp 1/1", alloc_gnt, rob_write); end
        alloc_req = 0;
    endtask

    task automatic test_in_order();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            alloc_req = 1; al_prd = PHYS_REG_IDX_W'(10 + i); al_lrd = ARCH_REG_IDX_W'(i + 1);
            tick();
        end
        alloc_req = 0;
        checks++; if (rob_tail !== 4'd3) begin errors++; $display("FAIL io_tail got %0h exp 3", rob_tail); end
        wb_valid = 1; wb_idx = 4'd2; tick();
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL io_no_commit_wb2 got %0h exp 0", commit_valid); end
        wb_idx = 4'd0; tick();
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL io_no_commit_wb0 got %0h exp 0", commit_valid); end
        wb_idx = 4'd1; tick();
        checks++; if (commit_valid !== 1'b1 || commit_phys_rd !== 6'd10 || commit_logical_rd !== 5'd1) begin errors++; $display("FAIL io_commit0 got v%0h p%0h l%0h exp v1 pa l1", commit_valid, commit_phys_rd, commit_logical_rd); end
        wb_valid = 0; tick();
        checks++; if (commit_valid !== 1'b1 || commit_phys_rd !== 6'd11) begin errors++; $display("FAIL io_commit1 got v%0h p%0h exp v1 pb", commit_valid, commit_phys_rd); end
        tick();
        checks++; if (commit_valid !== 1'b1 || commit_phys_rd !== 6'd12 || rob_empty !== 1'b1) begin errors++; $display("FAIL io_commit2 got v%0h p%0h e%0h exp v1 pc e1", commit_valid, commit_phys_rd, rob_empty); end
        tick();
        checks++; if (commit_valid !== 1'b0 || commit_phys_rd !== 6'd12) begin errors++; $display("FAIL io_hold got v%0h p%0h exp v0 pc", commit_valid, commit_phys_rd); end
    endtask

    task automatic test_full_wrap();
        int gnts;
        apply_reset();
        gnts = 0;
        for (int i = 0; i < ROB_LENGTH; i++) begin
            alloc_req = 1; al_prd = PHYS_REG_IDX_W'(i);
            #1;
            if (alloc_gnt === 1'b1) gnts++;
            tick();
        end
        checks++; if (gnts != ROB_LENGTH) begin errors++; $display("FAIL fw_grants got %0d exp %0d", gnts, ROB_LENGTH); end
        checks++; if (rob_full !== 1'b1 || rob_tail !== '0 || rob_head !== '0) begin errors++; $display("FAIL fw_full got f%0h t%0h h%0h exp f1 t0 h0", rob_full, rob_tail, rob_head); end
        #1;
        checks++; if (alloc_gnt !== 1'b0 || rob_write !== 1'b0) begin errors++; $display("FAIL fw_17th_gnt got %0h/%0h exp 0/0", alloc_gnt, rob_write); end
        alloc_req = 0; wb_valid = 1; wb_idx = '0;
        tick();
        wb_valid = 0; alloc_req = 1;
        #1;
        checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL fw_gnt_at_retire got %0h exp 0", alloc_gnt); end
        tick();
        checks++; if (commit_valid !== 1'b1 || commit_phys_rd !== 6'd0 || rob_full !== 1'b0) begin errors++; $display("FAIL fw_retire got v%0h p%0h f%0h exp v1 p0 f0", commit_valid, commit_phys_rd, rob_full); end
        checks++; if (alloc_gnt !== 1'b1) begin errors++; $display("FAIL fw_gnt_after got %0h exp 1", alloc_gnt); end
        tick();
        alloc_req = 0;
        checks++; if (rob_full !== 1'b1 || rob_tail !== 4'd1 || rob_head !== 4'd1) begin errors++; $display("FAIL fw_refill got f%0h t%0h h%0h exp f1 t1 h1", rob_full, rob_tail, rob_head); end
    endtask

    task automatic test_store_wait();
        apply_reset();
        alloc_req = 1; al_store = 1; al_prd = 6'd33; tick();
        alloc_req = 0; al_store = 0; wb_valid = 1; wb_idx = '0; tick();
        wb_valid = 0; tick();
        checks++; if (store_commit_valid !== 1'b1 || commit_valid !== 1'b0) begin errors++; $display("FAIL sw_start got s%0h c%0h exp s1 c0", store_commit_valid, commit_valid); end
        for (int k = 0; k < 4; k++) begin
            alloc_req = (k == 0); al_prd = 6'd7;
            tick();
            checks++; if (store_commit_valid !== 1'b1 || rob_head !== '0 || commit_valid !== 1'b0) begin errors++; $display("FAIL sw_hold%0d got s%0h h%0h c%0h exp s1 h0 c0", k, store_commit_valid, rob_head, commit_valid); end
        end
        alloc_req = 0;
        checks++; if (rob_tail !== 4'd2) begin errors++; $display("FAIL sw_alloc_during got %0h exp 2", rob_tail); end
        store_commit_ready = 1; tick();
        checks++; if (store_commit_valid !== 1'b0 || commit_valid !== 1'b1 || commit_is_store !== 1'b1 || commit_phys_rd !== 6'd33 || rob_head !== 4'd1) begin errors++; $display("FAIL sw_done got s%0h c%0h st%0h p%0h h%0h exp s0 c1 st1 p21 h1", store_commit_valid, commit_valid, commit_is_store, commit_phys_rd, rob_head); end
        store_commit_ready = 0; tick();
        checks++; if (commit_valid !== 1'b0 || store_commit_valid !== 1'b0) begin errors++; $display("FAIL sw_after got c%0h s%0h exp c0 s0", commit_valid, store_commit_valid); end
    endtask

    task automatic test_wb_alloc_collision();
        int bad;
        apply_reset();
        alloc_req = 1; al_prd = 6'd5; wb_valid = 1; wb_idx = '0; tick();
        alloc_req = 0; wb_valid = 0;
        bad = 0;
        repeat (3) begin tick(); if (commit_valid !== 1'b0 || rob_empty !== 1'b0) bad++; end
        checks++; if (bad != 0) begin errors++; $display("FAIL col_no_commit got %0d bad cycles exp 0", bad); end
        wb_valid = 1; wb_idx = '0; tick();
        wb_valid = 0; tick();
        checks++; if (commit_valid !== 1'b1 || commit_phys_rd !== 6'd5) begin errors++; $display("FAIL col_commit got v%0h p%0h exp v1 p5", commit_valid, commit_phys_rd); end
        alloc_req = 1; al_prd = 6'd44; tick();
        alloc_req = 0; wb_valid = 1; wb_idx = 4'd1; tick();
        wb_valid = 0; hv_en = 0;
        bad = 0;
        repeat (3) begin tick(); if (commit_valid !== 1'b0 || rob_head !== 4'd1) bad++; end
        checks++; if (bad != 0) begin errors++; $display("FAIL hv_stall got %0d bad cycles exp 0", bad); end
        hv_en = 1; tick();
        checks++; if (commit_valid !== 1'b1 || commit_phys_rd !== 6'd44) begin errors++; $display("FAIL hv_release got v%0h p%0h exp v1 p2c", commit_valid, commit_phys_rd); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        alloc_req = 1; al_store = 1; tick();
        alloc_req = 0; al_store = 0; wb_valid = 1; wb_idx = '0; tick();
        wb_valid = 0; tick();
        checks++; if (store_commit_valid !== 1'b1 || rob_tail !== 4'd1) begin errors++; $display("FAIL ar_pre got s%0h t%0h exp s1 t1", store_commit_valid, rob_tail); end
        #2 rst_n = 0;
        #1;
        checks++; if (store_commit_valid !== 1'b0 || rob_head !== '0 || rob_tail !== '0 || rob_empty !== 1'b1) begin errors++; $display("FAIL ar_drop got s%0h h%0h t%0h e%0h exp s0 h0 t0 e1", store_commit_valid, rob_head, rob_tail, rob_empty); end
        tick();
        rst_n = 1;
        tick();
    endtask

`ifdef ROB_FLUSH_EN
    task automatic test_flush();
        apply_reset();
        for (int i = 0; i < 5; i++) begin alloc_req = 1; tick(); end
        alloc_req = 0; wb_valid = 1; wb_idx = '0; tick();
        wb_valid = 0; flush = 1; alloc_req = 1;
        #1;
        checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL fl_gnt got %0h exp 0", alloc_gnt); end
        tick();
        flush = 0; alloc_req = 0;
        checks++; if (rob_empty !== 1'b1 || commit_valid !== 1'b0 || rob_tail !== '0 || store_commit_valid !== 1'b0) begin errors++; $display("FAIL fl_state got e%0h c%0h t%0h s%0h exp e1 c0 t0 s0", rob_empty, commit_valid, rob_tail, store_commit_valid); end
    endtask
`endif

    task automatic test_random();
        logic                 exp_gnt, ret, start, exp_scv;
        logic [ROB_IDX_W-1:0] exp_head, exp_tail;
        ent_t                 e;
        apply_reset();
        q.delete();
        for (int i = 0; i < ROB_LENGTH; i++) mdone[i] = 0;
        pend = 0; mtail = 0;
        last = '{idx: '0, st: 1'b0, lrd: '0, prd: '0, res: '0};
        for (int c = 0; c < 800; c++) begin
            alloc_req = ($urandom_range(0, 99) < 60);
            al_store  = ($urandom_range(0, 99) < 30);
            al_lrd    = ARCH_REG_IDX_W'($urandom);
            al_prd    = PHYS_REG_IDX_W'($urandom);
            al_res    = $urandom;
            wb_valid  = ($urandom_range(0, 99) < 50);
            if (q.size() > 0 && $urandom_range(0, 99) < 80) wb_idx = q[$urandom_range(0, q.size() - 1)].idx;
            else wb_idx = ROB_IDX_W'($urandom);
            store_commit_ready = ($urandom_range(0, 99) < 50);
            #1;
            exp_gnt = alloc_req && (q.size() < ROB_LENGTH);
            checks++; if (alloc_gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt c%0d got %0h exp %0h", c, alloc_gnt, exp_gnt); end
            ret = 0; start = 0;
            if (pend) ret = store_commit_ready;
            else if (q.size() > 0 && mdone[q[0].idx]) begin
                if (q[0].st) start = 1; else ret = 1;
            end
            exp_scv = start || (pend && !store_commit_ready);
            if (ret) last = q[0];
            if (wb_valid) mdone[wb_idx] = 1;
            if (exp_gnt) begin
                e.idx = ROB_IDX_W'(mtail); e.st = al_store; e.lrd = al_lrd; e.prd = al_prd; e.res = al_res;
                mdone[mtail] = 0;
                q.push_back(e);
                mtail = (mtail + 1) % ROB_LENGTH;
            end
            if (ret) void'(q.pop_front());
            pend = exp_scv;
            @(posedge clk);
            #1;
            exp_tail = ROB_IDX_W'(mtail);
            exp_head = (q.size() > 0) ? q[0].idx : exp_tail;
            checks++; if (commit_valid !== ret) begin errors++; $display("FAIL rnd_cv c%0d got %0h exp %0h", c, commit_valid, ret); end
            checks++; if (commit_logical_rd !== last.lrd || commit_phys_rd !== last.prd || commit_result !== last.res || commit_is_store !== last.st) begin errors++; $display("FAIL rnd_data c%0d got %0h/%0h/%0h/%0h exp %0h/%0h/%0h/%0h", c, commit_logical_rd, commit_phys_rd, commit_result, commit_is_store, last.lrd, last.prd, last.res, last.st); end
            checks++; if (store_commit_valid !== exp_scv) begin errors++; $display("FAIL rnd_scv c%0d got %0h exp %0h", c, store_commit_valid, exp_scv); end
            checks++; if (rob_head !== exp_head || rob_tail !== exp_tail) begin errors++; $display("FAIL rnd_ptrs c%0d got %0h/%0h exp %0h/%0h", c, rob_head, rob_tail, exp_head, exp_tail); end
            checks++; if (rob_empty !== (q.size() == 0) || rob_full !== (q.size() == ROB_LENGTH)) begin errors++; $display("FAIL rnd_occ c%0d got e%0h f%0h exp size %0d", c, rob_empty, rob_full, q.size()); end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < ROB_LENGTH; i++) begin
            st_store[i] = 0; st_lrd[i] = '0; st_prd[i] = '0; st_res[i] = '0;
        end
        test_reset();
        test_in_order();
        test_full_wrap();
        test_store_wait();
        test_wb_alloc_collision();
        test_async_reset();
`ifdef ROB_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout reached without completing the run");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- Head-side controller for the reorder buffer; the storage array remains a separate block.
- Owns the head/tail pointers and the occupancy count, and drives the storage write enable and tail index at dispatch.
- Tracks per-entry completion from writeback and retires the head entry in program order.
- Produces architectural-commit pulses for the rename/regfile side and a store-commit handshake toward the LSU.

Parameters:
- ROB_LENGTH, 16, number of ROB entries; must be a power of two.
- ROB_IDX_W, $clog2(ROB_LENGTH), head/tail index width.
- ARCH_REG_IDX_W, PHYS_REG_IDX_W, INT_DATA_W: taken from general_defines, not redeclared.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_req  in  1  dispatch requests one entry
- alloc_gnt  out  1  entry granted this cycle (combinational)
- rob_write  out  1  storage write enable; equals alloc_gnt
- rob_tail  out  ROB_IDX_W  storage write index
- rob_head  out  ROB_IDX_W  storage read index
- rob_full  out  1  count == ROB_LENGTH
- rob_empty  out  1  count == 0
- wb_valid  in  1  execution result complete
- wb_idx  in  ROB_IDX_W  ROB index being completed
- head_valid  in  1  storage head entry valid field
- head_is_store  in  1  storage head entry is_store field
- head_logical_rd  in  ARCH_REG_IDX_W  storage head field
- head_phys_rd  in  PHYS_REG_IDX_W  storage head field
- head_result  in  INT_DATA_W  storage head field
- commit_valid  out  1  one-cycle retire pulse (registered)
- commit_logical_rd  out  ARCH_REG_IDX_W  retired arch register
- commit_phys_rd  out  PHYS_REG_IDX_W  retired phys register
- commit_result  out  INT_DATA_W  retired value
- commit_is_store  out  1  retired entry was a store
- store_commit_valid  out  1  request LSU to perform the head store (registered)
- store_commit_ready  in  1  LSU accepts the store

Behaviour:
- Reset (async, rst_n=0):
  - head, tail, count = 0; done vector = 0; state = RUN.
  - commit_* outputs and store_commit_valid = 0.
  - Reset asserted mid-store-handshake abandons the handshake immediately.
- Allocation:
  - alloc_gnt = alloc_req & ~rob_full.
  - On grant: done[tail] <= 0; tail <= tail+1, wrapping modulo ROB_LENGTH; count increments.
  - When full, alloc is refused even if a commit occurs in the same cycle; no bypass.
- Writeback: wb_valid sets done[wb_idx] <= 1.
  - If wb_idx equals the tail being allocated in the same cycle, the allocation clear wins.
  - A writeback to the head entry is visible to commit logic on the next cycle.
- head_ok = ~rob_empty & head_valid & done[head].
- FSM states RUN and STORE_WAIT:
  - RUN, head_ok & ~head_is_store: next edge drives commit_valid=1 and the head fields into commit_*; head <= head+1; count decrements. One retire per cycle maximum.
  - RUN, head_ok & head_is_store: next edge drives store_commit_valid=1; state goes to STORE_WAIT. Head does not move.
  - STORE_WAIT: store_commit_valid is held at 1 until a cycle where store_commit_ready=1.
  - On that ready edge: store_commit_valid=0; commit_valid=1 with commit_is_store=1; head advances; count decrements; state goes to RUN.
  - While a store is waiting, allocation continues if the ROB is not full.
- Count update on a simultaneous grant and retire: count is unchanged; head and tail both advance.
- commit_valid is 0 in every cycle without a retire. commit_* data holds its last value when commit_valid=0.
- Pointers wrap from ROB_LENGTH-1 to 0. Full versus empty is distinguished by count, never by pointer equality.
- A head entry with head_valid=0 while count>0 stalls commit and is not skipped.

Optional Feature:
- Macro ROB_FLUSH_EN adds the input port flush (1 bit).
- With the macro defined, flush=1 on a clock edge does all of the following:
  - head, tail, count and the done vector go to 0; state goes to RUN.
  - store_commit_valid goes to 0 and no commit occurs that cycle.
  - flush overrides alloc, writeback and commit; alloc_gnt=0 while flush=1.
- Without the macro: no flush port exists and the ROB empties only by retirement.

Decomposition:
- The rob_commit_state_t enum (RUN, STORE_WAIT) goes in general_defines.
- ROB_LENGTH and ROB_IDX_W are already provided there and are reused.
- Pointer/count bookkeeping is a natural sub-module, rob_ptr_ctrl. The inputs are alloc_gnt and the retire strobe; the outputs are head, tail, count, full and empty.
- The FSM and done vector stay in the top.

Test Plan:
- Reset, then allocate 3 entries with wb at idx 2, 0, 1 on consecutive cycles -> commit_valid pulses in order for idx 0, 1, 2; idx 0 retires the cycle after its wb; count ends at 0.
- Allocate 16 entries -> rob_full=1; a 17th alloc_req gets alloc_gnt=0; tail wraps to 0.
- Same cycle as one retire from full, alloc_req=1 -> gnt=0; the following cycle gnt=1 and count returns to 16.
- Store at head, done, store_commit_ready held 0 for 4 cycles -> store_commit_valid stays 1 and head is stable; ready=1 -> commit_valid=1 with commit_is_store=1 next edge.
- wb_valid with wb_idx==tail and alloc on the same edge -> done[tail] reads 0; the entry does not commit until a new wb.
- rst_n=0 asserted asynchronously mid STORE_WAIT -> store_commit_valid drops without a clock edge; head=tail=0. With ROB_FLUSH_EN: flush with 5 entries in flight -> rob_empty=1 next cycle and no commit pulse.
